// File: rtl/nibble_serial_alu.sv
// ---------------------------------------------------------------------------
// nibble_serial_alu : multi-cycle ADD/SUB/CMP(/ADC) unit, one nibble per clock
// Optional macro NIBBLE_ALU_ADC_EN enables op 11 = ADC.       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module FA_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[4];
endmodule

module nibble_serial_alu #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_c,
  output logic                 flag_v
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic                    r_carry;
  logic                    r_cmp;
  logic [NIBBLES-1:0][3:0] r_a;
  logic [NIBBLES-1:0][3:0] r_b;
  logic [NIBBLES-1:0][3:0] r_work;
  logic [NIBBLES-1:0][3:0] w_r;
  logic [3:0]              w_sum;
  logic                    w_cout;
  logic                    w_sub;
  logic                    w_cin_init;
  logic                    w_last;

  FA_4 u_fa (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_sub  = (op == 2'b01) || (op == 2'b10);
  assign w_last = (r_idx == IW'(NIBBLES - 1));

`ifdef NIBBLE_ALU_ADC_EN
  assign w_cin_init = w_sub || ((op == 2'b11) && flag_c);
`else
  assign w_cin_init = w_sub;
`endif

  // Full W-bit sum as it stands once the current nibble is folded in.
  always_comb begin
    w_r        = r_work;
    w_r[r_idx] = w_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cmp   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_cmp   <= (op == 2'b10);
            r_carry <= w_cin_init;
            r_idx   <= '0;
            r_work  <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        RUN: begin
          r_work  <= w_r;
          r_carry <= w_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_state <= DONE;
            done    <= 1'b1;
            if (!r_cmp) result <= w_r;
            flag_z <= (w_r == '0);
            flag_n <= w_r[NIBBLES-1][3];
            flag_c <= w_cout;
            flag_v <= (r_a[NIBBLES-1][3] == r_b[NIBBLES-1][3]) &&
                      (w_r[NIBBLES-1][3] != r_a[NIBBLES-1][3]);
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

`default_nettype wire
